window_gen3x3: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution core. It accepts one 10-bit pixel per cycle in raster order and buffers the two previous image rows. For every pixel that completes a full 3x3 neighbourhood, it emits the 90-bit packed window on the same bus layout the convolution core consumes. Valid-only windows are produced (no padding), so an IMG_W x IMG_H frame yields (IMG_W-2) x (IMG_H-2) windows.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/row_delay_line.sv | 29 ++
 rtl/window_gen3x3.sv | 157 +++++++++++++++
 tb/tb_window_gen3x3.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 window generator and the convolution core.
// Window slots are row-major: slot 0 is top-left, slot 8 is bottom-right,
// and slot s occupies bits [s*DATA_W +: DATA_W] of the packed window.
package conv_pkg;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned K      = 3;
    localparam int unsigned WIN_W  = K * K * DATA_W;

    // Window-slot indices shared with the convolution core
    localparam int unsigned TL = 0;
    localparam int unsigned TM = 1;
    localparam int unsigned TR = 2;
    localparam int unsigned ML = 3;
    localparam int unsigned MM = 4;
    localparam int unsigned MR = 5;
    localparam int unsigned BL = 6;
    localparam int unsigned BM = 7;
    localparam int unsigned BR = 8;

    typedef logic [DATA_W-1:0] pixel_t;

    // Packed so that element 0 lands in the low bits of the 90-bit bus
    typedef pixel_t [K*K-1:0] window_t;

    // Minimum address width for a memory of the given depth
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/row_delay_line.sv
// One image row of pixel storage, addressed by column.
// Read is asynchronous and returns the old contents when the same address is
// written on the coming edge (read-before-write). Contents are never reset.
module row_delay_line
    import conv_pkg::*;
#(
    parameter int unsigned Depth = 32,
    parameter int unsigned AddrW = addr_width(Depth)
) (
    input  logic             clk_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic             we_i,
    input  pixel_t           wdata_i,
    output pixel_t           rdata_o
);

    pixel_t mem [Depth];

    // Old value is visible for the whole cycle the write is set up
    assign rdata_o = mem[addr_i];

    // Row storage write port, no reset by design
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen3x3.sv
// Streaming 3x3 window generator feeding the convolution core.
// Accepts one raster-order pixel per cycle, keeps the two previous rows in
// row_delay_line instances and emits only fully populated (unpadded) windows.
// Optional macro WINDOW_READY_EN adds the i_ready backpressure input; without
// it o_ready is tied high and o_valid is a one-cycle pulse per window.
module window_gen3x3
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic             o_ready,
`ifdef WINDOW_READY_EN
    input  logic             i_ready,
`endif
    output logic             o_valid,
    output logic [WIN_W-1:0] o_window,
    output logic             o_last
);

    localparam int unsigned COL_W = addr_width(IMG_W);
    localparam int unsigned ROW_W = addr_width(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    window_t          win_q, win_d;
    window_t          out_win_q, out_win_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic   accept;
    logic   col_end;
    logic   row_end;
    logic   emit;
    pixel_t line1_rd;
    pixel_t line2_rd;

    // Previous row
    row_delay_line #(
        .Depth (IMG_W),
        .AddrW (COL_W)
    ) u_line1 (
        .clk_i   (i_clk),
        .addr_i  (col_q),
        .we_i    (accept),
        .wdata_i (i_data),
        .rdata_o (line1_rd)
    );

    // Row before that; fed from line1's old value so the two shift together
    row_delay_line #(
        .Depth (IMG_W),
        .AddrW (COL_W)
    ) u_line2 (
        .clk_i   (i_clk),
        .addr_i  (col_q),
        .we_i    (accept),
        .wdata_i (line1_rd),
        .rdata_o (line2_rd)
    );

`ifdef WINDOW_READY_EN
    // A held window blocks new pixels until downstream takes it
    assign o_ready = !valid_q || i_ready;
`else
    assign o_ready = 1'b1;
`endif

    // Accept decode, position flags and window-emit gating
    always_comb begin
        accept  = i_valid && o_ready;
        col_end = (col_q == COL_W'(IMG_W - 1));
        row_end = (row_q == ROW_W'(IMG_H - 1));
        // row>=2 guarantees every delay-line entry used came from this frame
        emit    = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    end

    // Raster position counters
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shifts left one column; new right column is top/mid/bottom
    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d[TL] = win_q[TM];
            win_d[TM] = win_q[TR];
            win_d[TR] = line2_rd;
            win_d[ML] = win_q[MM];
            win_d[MM] = win_q[MR];
            win_d[MR] = line1_rd;
            win_d[BL] = win_q[BM];
            win_d[BM] = win_q[BR];
            win_d[BR] = i_data;
        end
    end

    // Output stage: load on emit, otherwise retire (or hold while stalled)
    always_comb begin
        valid_d   = valid_q;
        last_d    = last_q;
        out_win_d = out_win_q;
        if (emit) begin
            valid_d   = 1'b1;
            last_d    = row_end && col_end;
            out_win_d = win_d;
`ifdef WINDOW_READY_EN
        end else if (i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
`else
        end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
`endif
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            out_win_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            out_win_q <= out_win_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_last   = last_q;
    assign o_window = out_win_q;

endmodule

// File: tb/tb_window_gen3x3.sv
// Directed bench for window_gen3x3: a 4x4 instance for the main scenarios and
// a 3x3 instance for the single-window frame. Build with WINDOW_READY_EN to
// also exercise the backpressure stall.
`timescale 1ns/1ps
module tb_window_gen3x3;

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [9:0]  in_data = '0;
    logic        out_ready;
    logic        rdy_in = 1'b1;
    logic        out_valid;
    logic [89:0] out_window;
    logic        out_last;

    logic        v2 = 1'b0;
    logic [9:0]  d2 = '0;
    logic        r2o;
    logic        rdy2 = 1'b1;
    logic        v2o;
    logic [89:0] w2o;
    logic        l2o;

    always #5 clk = ~clk;

    window_gen3x3 #(.IMG_W(4), .IMG_H(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .i_data   (in_data),
        .o_ready  (out_ready),
`ifdef WINDOW_READY_EN
        .i_ready  (rdy_in),
`endif
        .o_valid  (out_valid),
        .o_window (out_window),
        .o_last   (out_last)
    );

    window_gen3x3 #(.IMG_W(3), .IMG_H(3)) dut3 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (v2),
        .i_data   (d2),
        .o_ready  (r2o),
`ifdef WINDOW_READY_EN
        .i_ready  (rdy2),
`endif
        .o_valid  (v2o),
        .o_window (w2o),
        .o_last   (l2o)
    );

    // Hand-computed 4x4 windows (pixel = row*4+col), in emission order
    int exp_tab [4][9] = '{
        '{0, 1, 2, 4, 5, 6, 8, 9, 10},
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };

    function automatic logic [89:0] exp_win(input int idx, input int base);
        logic [89:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*10 +: 10] = 10'(exp_tab[idx][k] + base);
        end
        return w;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Window logs from handshaken outputs
    logic [89:0] wq[$];
    bit          lq[$];
    int          cq[$];
    logic [89:0] wq2[$];
    bit          lq2[$];

    bit acc_edge = 1'b0;
    bit chk_en   = 1'b0;
    int bad_valid = 0;

    always @(posedge clk) acc_edge <= in_valid && out_ready && !rst;

    always @(negedge clk) begin
        if (!rst && out_valid && rdy_in) begin
            wq.push_back(out_window);
            lq.push_back(out_last);
            cq.push_back(cyc);
            if (chk_en && !acc_edge) bad_valid++;
        end
        if (!rst && v2o && rdy2) begin
            wq2.push_back(w2o);
            lq2.push_back(l2o);
        end
    end

    int acc10 = 0;

    // Present one pixel and hold it until accepted; called at posedge+1
    task automatic send_px(input logic [9:0] d, input bit rnd);
        bit got;
        int n;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            got = out_ready;
            @(posedge clk);
            #1;
            if (got) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: pixel %0d not accepted, required accept within 100 cycles", d);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit rnd);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send_px(10'(base + r * 4 + c), rnd);
                if (r == 2 && c == 2) acc10 = cyc;
            end
        end
    endtask

    task automatic clear_logs();
        wq.delete();
        lq.delete();
        cq.delete();
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (out_window !== 90'd0) begin
            errors++; $display("FAIL reset_window: got %h, required 0", out_window);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++; $display("FAIL reset_last: got %b, required 0", out_last);
        end
        checks++;
        if (out_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", out_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Compare the log against one 4x4 frame at the given base
    task automatic check_frame(input string name, input int first, input int base);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wq.size() <= first + i) begin
                errors++;
                $display("FAIL %s_missing%0d: got %0d windows, required window %0d", name, i,
                         wq.size(), first + i + 1);
            end else begin
                if (wq[first+i] !== exp_win(i, base)) begin
                    errors++;
                    $display("FAIL %s_win%0d: got %h, required %h", name, i, wq[first+i],
                             exp_win(i, base));
                end
                checks++;
                if (lq[first+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL %s_last%0d: got %b, required %b", name, i, lq[first+i], i == 3);
                end
            end
        end
    endtask

    task automatic test_basic();
        clear_logs();
        send_frame(0, 1'b0);
        drain();
        checks++;
        if (wq.size() !== 4) begin
            errors++; $display("FAIL basic_count: got %0d, required 4", wq.size());
        end
        check_frame("basic", 0, 0);
        checks++;
        if (cq.size() == 0 || cq[0] !== acc10) begin
            errors++;
            $display("FAIL basic_latency: first window at cycle %0d, required cycle %0d",
                     (cq.size() == 0) ? -1 : cq[0], acc10);
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        bad_valid = 0;
        chk_en = 1'b1;
        send_frame(0, 1'b1);
        drain();
        chk_en = 1'b0;
        checks++;
        if (wq.size() !== 4) begin
            errors++; $display("FAIL gaps_count: got %0d, required 4", wq.size());
        end
        check_frame("gaps", 0, 0);
        checks++;
        if (bad_valid !== 0) begin
            errors++; $display("FAIL gaps_spurious_valid: got %0d, required 0", bad_valid);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        drain();
        checks++;
        if (wq.size() !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d, required 8", wq.size());
        end
        check_frame("b2b_f1", 0, 0);
        check_frame("b2b_f2", 4, 100);
    endtask

    task automatic test_reset_midframe();
        clear_logs();
        for (int p = 0; p < 10; p++) send_px(10'(p), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (out_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready: got %b, required 1", out_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        send_frame(0, 1'b0);
        drain();
        checks++;
        if (wq.size() !== 4) begin
            errors++; $display("FAIL midrst_count: got %0d, required 4", wq.size());
        end
        check_frame("midrst", 0, 0);
    endtask

`ifdef WINDOW_READY_EN
    task automatic test_stall();
        clear_logs();
        fork
            send_frame(0, 1'b0);
            begin
                bit found;
                int n;
                found = 1'b0;
                n = 0;
                while (!found && n < 200) begin
                    @(posedge clk);
                    #2;
                    if (out_valid && out_window === exp_win(1, 0)) found = 1'b1;
                    n++;
                end
                checks++;
                if (!found) begin
                    errors++; $display("FAIL stall_seen: second window not seen, required within 200 cycles");
                end
                rdy_in = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if (out_window !== exp_win(1, 0)) begin
                        errors++;
                        $display("FAIL stall_hold%0d: got %h, required %h", k, out_window, exp_win(1, 0));
                    end
                    checks++;
                    if (out_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_ready%0d: got ready=%b valid=%b, required ready=0 valid=1",
                                 k, out_ready, out_valid);
                    end
                    @(posedge clk);
                    #2;
                end
                rdy_in = 1'b1;
            end
        join
        drain();
        checks++;
        if (wq.size() !== 4) begin
            errors++; $display("FAIL stall_count: got %0d, required 4", wq.size());
        end
        check_frame("stall", 0, 0);
    endtask
`endif

    task automatic test_min_frame();
        logic [89:0] w;
        for (int k = 0; k < 9; k++) w[k*10 +: 10] = 10'(k);
        wq2.delete();
        lq2.delete();
        for (int p = 0; p < 9; p++) begin
            v2 = 1'b1;
            d2 = 10'(p);
            @(posedge clk);
            #1;
        end
        v2 = 1'b0;
        drain();
        checks++;
        if (wq2.size() !== 1) begin
            errors++; $display("FAIL min_count: got %0d, required 1", wq2.size());
        end
        if (wq2.size() > 0) begin
            checks++;
            if (wq2[0] !== w) begin
                errors++; $display("FAIL min_win: got %h, required %h", wq2[0], w);
            end
            checks++;
            if (lq2[0] !== 1'b1) begin
                errors++; $display("FAIL min_last: got %b, required 1", lq2[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
`ifdef WINDOW_READY_EN
        test_stall();
`endif
        test_min_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
